mc14500b_program_loader: RTL and testbench

Byte-stream program loader that sits directly upstream of the MC14500B core. It receives framed program images over a valid/ready byte interface and assembles 12-bit instruction words ({opcode[3:0], addr[7:0]}). It drives the core's program_write/program_cmd port and sequences the core reset: it clears the core before loading and restarts it after a checksum-verified image.

---
 rtl/mc14500b_program_loader.sv | 89 ++++++++
 tb/tb_mc14500b_program_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mc14500b_program_loader.sv
// mc14500b_program_loader: frames a byte stream into 12-bit program words for the MC14500B core and sequences its reset
module mc14500b_program_loader #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         RST_CYCLES = 2,
  parameter int         WRITE_GAP  = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [11:0] program_cmd_o,
  output logic        program_write_o,
  output logic        core_rst_o,
  output logic        busy_o,
  output logic        error_o,
  output logic [7:0]  words_loaded_o
);
  typedef enum logic [3:0] {
    IDLE, PRE_RST, GET_CNT, GET_HI, GET_LO, WRITE, GAP, GET_CSUM, POST_RST, ERROR
  } state_t;
  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = 8'(WRITE_GAP - 1);
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, n_q, csum_q, words_q;
  logic [3:0]  hi_q;
  logic [11:0] cmd_q;
  logic        ready_q, write_q, core_rst_q, busy_q, error_q;
  logic        acc;
  assign acc             = rx_valid_i & ready_q;
  assign rx_ready_o      = ready_q;
  assign program_cmd_o   = cmd_q;
  assign program_write_o = write_q;
  assign core_rst_o      = core_rst_q;
  assign busy_o          = busy_q;
  assign error_o         = error_q;
  assign words_loaded_o  = words_q;
  // next-state decode; payload bytes equal to SYNC_BYTE are plain data, no resync mid-frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ERROR: if (acc && rx_data_i == SYNC_BYTE) state_d = PRE_RST;
      PRE_RST:     if (cnt_q == RST_LAST) state_d = GET_CNT;
      GET_CNT:     if (acc) state_d = (rx_data_i == 8'h00) ? ERROR : GET_HI;
      GET_HI:      if (acc) state_d = (rx_data_i[7:4] != 4'h0) ? ERROR : GET_LO;
      GET_LO:      if (acc) state_d = WRITE;
      WRITE:       state_d = GAP;
      GAP:         if (cnt_q == GAP_LAST) state_d = (words_q < n_q) ? GET_HI : GET_CSUM;
      GET_CSUM:    if (acc) state_d = (rx_data_i == csum_q) ? POST_RST : ERROR;
      POST_RST:    if (cnt_q == RST_LAST) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end
  // state, datapath and outputs registered from the upcoming state so they are valid on state entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      csum_q     <= '0;
      words_q    <= '0;
      hi_q       <= '0;
      cmd_q      <= '0;
      ready_q    <= 1'b0;
      write_q    <= 1'b0;
      core_rst_q <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= (state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
      ready_q    <= state_d inside {IDLE, GET_CNT, GET_HI, GET_LO, GET_CSUM, ERROR};
      busy_q     <= !(state_d inside {IDLE, ERROR});
      core_rst_q <= state_d != IDLE;
      error_q    <= state_d == ERROR;
      write_q    <= state_d == WRITE;
      if (state_q inside {IDLE, ERROR} && state_d == PRE_RST) begin
        csum_q  <= '0;
        words_q <= '0;
      end else if (acc && state_q inside {GET_CNT, GET_HI, GET_LO}) begin
        csum_q <= csum_q ^ rx_data_i;
      end
      if (acc && state_q == GET_CNT) n_q <= rx_data_i;
      if (acc && state_q == GET_HI) hi_q <= rx_data_i[3:0];
      if (acc && state_q == GET_LO) cmd_q <= {hi_q, rx_data_i};
      if (state_d == WRITE) words_q <= words_q + 8'd1;
    end
  end
endmodule

// File: tb/tb_mc14500b_program_loader.sv
// tb_mc14500b_program_loader: scoreboard bench for the program loader
module tb_mc14500b_program_loader;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready_o;
  logic [11:0] program_cmd_o;
  logic        program_write_o;
  logic        core_rst_o;
  logic        busy_o;
  logic        error_o;
  logic [7:0]  words_loaded_o;
  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];
  logic [7:0]  bq[$];

  mc14500b_program_loader dut (
    .clk_i(clk), .rst_ni(rst_ni), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready_o), .program_cmd_o(program_cmd_o), .program_write_o(program_write_o),
    .core_rst_o(core_rst_o), .busy_o(busy_o), .error_o(error_o), .words_loaded_o(words_loaded_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int bub);
    if (bub > 0) begin
      rx_valid = 1'b0;
      repeat (bub) @(posedge clk);
      #1;
    end
    rx_data = b;
    rx_valid = 1'b1;
    for (int t = 0; t < 50 && !rx_ready_o; t++) @(negedge clk);
    if (!rx_ready_o) chk("send_timeout", 32'(rx_ready_o), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int bub);
    foreach (bq[i]) send(bq[i], bub);
  endtask

  task automatic expect_word(input logic [11:0] cmd, input logic [7:0] wl);
    exp_q.push_back({wl, cmd});
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 30 && busy_o; t++) @(negedge clk);
    chk("busy_drop", 32'(busy_o), 32'd0);
  endtask

  // monitor: pops expected words on each write strobe and checks non-receiving run lengths
  initial begin
    int run = 0;
    int cyc = 0;
    int last_wr = -10;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_ni) begin
        run = 0;
        last_wr = -10;
      end else begin
        if (busy_o && !rx_ready_o) run++;
        else if (run > 0) begin
          chk("stall_run_len", 32'(run), 32'd2);
          run = 0;
        end
        if (program_write_o) begin
          chk("ready_low_in_write", 32'(rx_ready_o), 32'd0);
          chk("write_not_back_to_back", 32'(cyc - last_wr > 1), 32'd1);
          last_wr = cyc;
          if (exp_q.size() == 0) chk("unexpected_write", 32'(program_cmd_o), 32'hFFFFFFFF);
          else begin
            logic [19:0] e;
            e = exp_q.pop_front();
            chk("program_cmd", 32'(program_cmd_o), 32'(e[11:0]));
            chk("words_at_write", 32'(words_loaded_o), 32'(e[19:12]));
          end
        end
      end
    end
  end

  initial begin
    #1;
    chk("rst_ready", 32'(rx_ready_o), 0);
    chk("rst_outs", {program_cmd_o, program_write_o, core_rst_o, busy_o, error_o, words_loaded_o}, 0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ready", 32'(rx_ready_o), 32'd1);
    // good frame, valid held high
    expect_word(12'h6FF, 8'd1);
    expect_word(12'h800, 8'd2);
    bq = {8'hA5, 8'h02, 8'h06, 8'hFF, 8'h08, 8'h00, 8'hF3};
    frame(0);
    chk("good_core_rst_post", 32'(core_rst_o), 32'd1);
    wait_idle();
    chk("good_end", {core_rst_o, error_o, rx_ready_o, words_loaded_o}, {1'b0, 1'b0, 1'b1, 8'd2});
    // bad checksum: words still written, then ERROR
    expect_word(12'h6FF, 8'd1);
    expect_word(12'h800, 8'd2);
    bq = {8'hA5, 8'h02, 8'h06, 8'hFF, 8'h08, 8'h00, 8'hF2};
    frame(0);
    chk("badcs_state", {error_o, core_rst_o, busy_o, words_loaded_o}, {1'b1, 1'b1, 1'b0, 8'd2});
    // recovery from ERROR with a correct frame
    expect_word(12'h6FF, 8'd1);
    expect_word(12'h800, 8'd2);
    bq = {8'hA5, 8'h02, 8'h06, 8'hFF, 8'h08, 8'h00, 8'hF3};
    frame(0);
    wait_idle();
    chk("recover_end", {core_rst_o, error_o, words_loaded_o}, {1'b0, 1'b0, 8'd2});
    // noise dropped in IDLE, then N=0
    send(8'h00, 0);
    send(8'hFF, 0);
    rx_valid = 1'b0;
    #1;
    chk("noise_no_effect", {busy_o, core_rst_o, error_o, words_loaded_o}, {1'b0, 1'b0, 1'b0, 8'd2});
    bq = {8'hA5, 8'h00};
    frame(0);
    chk("n0_error", {error_o, core_rst_o, busy_o, words_loaded_o}, {1'b1, 1'b1, 1'b0, 8'd0});
    // illegal hi byte, started from ERROR
    bq = {8'hA5, 8'h01, 8'h16};
    frame(0);
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("badhi_error", {error_o, core_rst_o, busy_o, words_loaded_o}, {1'b1, 1'b1, 1'b0, 8'd0});
    // bubbles between bytes, SYNC value as lo payload
    expect_word(12'hA5C, 8'd1);
    expect_word(12'h3A5, 8'd2);
    expect_word(12'hF00, 8'd3);
    bq = {8'hA5, 8'h03, 8'h0A, 8'h5C, 8'h03, 8'hA5, 8'h0F, 8'h00, 8'hFC};
    frame(2);
    rx_valid = 1'b0;
    wait_idle();
    chk("bubble_end", {core_rst_o, error_o, words_loaded_o}, {1'b0, 1'b0, 8'd3});
    // async reset in GAP after the first word of a 3-word frame
    expect_word(12'h123, 8'd1);
    bq = {8'hA5, 8'h03, 8'h01, 8'h23};
    frame(0);
    chk("write_now", 32'(program_write_o), 32'd1);
    @(posedge clk);
    #1;
    chk("gap_state", {program_write_o, rx_ready_o, busy_o, words_loaded_o}, {1'b0, 1'b0, 1'b1, 8'd1});
    rst_ni = 1'b0;
    rx_valid = 1'b0;
    #1;
    chk("async_rst_outs", {rx_ready_o, program_cmd_o, program_write_o, core_rst_o, busy_o, error_o, words_loaded_o}, 0);
    exp_q.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    expect_word(12'h456, 8'd1);
    expect_word(12'h123, 8'd2);
    bq = {8'hA5, 8'h02, 8'h04, 8'h56, 8'h01, 8'h23, 8'h72};
    frame(0);
    rx_valid = 1'b0;
    wait_idle();
    chk("after_rst_end", {core_rst_o, error_o, words_loaded_o}, {1'b0, 1'b0, 8'd2});
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
